// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-port 32-bit word memory behind a req/ack handshake. Each request is
// captured in IDLE, held through WAIT_CYCLES wait states, and completed with a
// one-cycle ack in RESP. Transactions are strictly serialized, so a read always
// sees the result of every earlier completed write.

module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,  // wait states before each response, 0..15
  parameter int ADDR_W      = 6   // word-address width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              busy
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        wait_cnt_r;
  logic              req_we_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [31:0]       req_wdata_r;
  logic [31:0]       mem_r [DEPTH];

  // Access qualifiers for the edge that enters RESP.
  logic              enter_resp_s;
  logic              acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [31:0]       acc_wdata_s;

  // Decide whether this edge enters RESP and which request fields drive the access.
  // With zero wait states the capture and the access share one edge, so the
  // live inputs are used (they are exactly what gets captured on that edge).
  always_comb begin
    enter_resp_s = 1'b0;
    acc_we_s     = req_we_r;
    acc_addr_s   = req_addr_r;
    acc_wdata_s  = req_wdata_r;
    case (state_r)
      IDLE: begin
        if (req && (WAIT_CYCLES == 0)) begin
          enter_resp_s = 1'b1;
          acc_we_s     = we;
          acc_addr_s   = addr;
          acc_wdata_s  = wdata;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      WAIT: begin
        // Treating 0 like 1 keeps the counter from ever wrapping.
        if (wait_cnt_r <= 4'd1) begin
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      RESP: begin
        enter_resp_s = 1'b0;
      end
      default: begin
        enter_resp_s = 1'b0;
      end
    endcase
  end

  // Control FSM: request capture, wait counting and the registered ack/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 4'd0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      req_we_r    <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            req_we_r    <= we;
            req_addr_r  <= addr;
            req_wdata_r <= wdata;
            busy        <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_r    <= RESP;
              ack        <= 1'b1;
              wait_cnt_r <= 4'd0;
            end else begin
              state_r    <= WAIT;
              wait_cnt_r <= WAIT_INIT;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          if (enter_resp_s) begin
            state_r    <= RESP;
            ack        <= 1'b1;
            wait_cnt_r <= 4'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          ack     <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          wait_cnt_r <= 4'd0;
          ack        <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Storage and read-data register: cleared on reset, accessed only when entering RESP.
  // Because a reset in WAIT or RESP clears the whole array, a captured but
  // uncommitted write can never land afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
      rdata <= 32'h0;
    end else if (enter_resp_s) begin
      if (acc_we_s) begin
        mem_r[acc_addr_s] <= acc_wdata_s;
      end else begin
        rdata <= mem_r[acc_addr_s];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: a WAIT_CYCLES=2 instance for the
// main sequence and a WAIT_CYCLES=0 instance for the zero-wait timing.

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic        ack, busy;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [5:0]  addr0;
  logic [31:0] wdata0;
  logic        ack0, busy0;
  logic [31:0] rdata0;

  int vectors     = 0;
  int miscompares = 0;

  data_mem_responder #(.WAIT_CYCLES(2), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy)
  );

  data_mem_responder #(.WAIT_CYCLES(0), .ADDR_W(6)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .busy(busy0)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a read on the WAIT_CYCLES=2 instance and wait (bounded) for its ack.
  task automatic read_word(input logic [5:0] a, output logic [31:0] d, output logic got);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    tick();
    req = 1'b0;
    got = 1'b0;
    d   = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (ack === 1'b1) begin
        got = 1'b1;
        d   = rdata;
        break;
      end
      tick();
    end
    if (got) tick();
  endtask

  logic [31:0] rd;
  logic        got;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 6'd0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 6'd0; wdata0 = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_ack",   {31'h0, ack},  32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    chk("rst_rdata", rdata,         32'h0);
    chk("rst_ack0",  {31'h0, ack0}, 32'h0);
    chk("rst_busy0", {31'h0, busy0}, 32'h0);

    // Reset has priority over a simultaneous request
    req = 1'b1; we = 1'b0; addr = 6'd5;
    tick();
    chk("rst_prio_busy", {31'h0, busy}, 32'h0);

    // First edge with rst=0 accepts the read of addr 5 (edge N)
    rst = 1'b0;
    tick();
    chk("rd5_n_busy", {31'h0, busy}, 32'h1);
    chk("rd5_n_ack",  {31'h0, ack},  32'h0);
    req = 1'b0;
    tick();
    chk("rd5_n1_busy", {31'h0, busy}, 32'h1);
    chk("rd5_n1_ack",  {31'h0, ack},  32'h0);
    tick();
    chk("rd5_n2_ack",   {31'h0, ack},  32'h1);
    chk("rd5_n2_busy",  {31'h0, busy}, 32'h1);
    chk("rd5_n2_rdata", rdata,         32'h0);
    tick();
    chk("rd5_n3_ack",  {31'h0, ack},  32'h0);
    chk("rd5_n3_busy", {31'h0, busy}, 32'h0);

    // Write DEADBEEF to the top address; wdata changes after acceptance are ignored
    req = 1'b1; we = 1'b1; addr = 6'h3F; wdata = 32'hDEADBEEF;
    tick();
    req = 1'b0; we = 1'b0; addr = 6'h00; wdata = 32'h0BAD0BAD;
    tick();
    tick();
    chk("wr3f_ack",   {31'h0, ack}, 32'h1);
    chk("wr3f_rdata", rdata,        32'h0);
    tick();
    chk("wr3f_done_ack", {31'h0, ack}, 32'h0);

    req = 1'b1; we = 1'b0; addr = 6'h3F;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk("rd3f_ack",   {31'h0, ack}, 32'h1);
    chk("rd3f_rdata", rdata,        32'hDEADBEEF);
    tick();

    // Continuous req: acceptances every 4 edges, inputs changing every cycle
    req = 1'b1; we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        addr  = 6'(8 + 4 * k + c);
        wdata = 32'hA0000000 | 32'(k << 4) | 32'(c);
        tick();
        chk($sformatf("cont_k%0d_c%0d_busy", k, c), {31'h0, busy}, (c != 3) ? 32'h1 : 32'h0);
        chk($sformatf("cont_k%0d_c%0d_ack", k, c),  {31'h0, ack},  (c == 2) ? 32'h1 : 32'h0);
      end
    end
    req = 1'b0; we = 1'b0;

    read_word(6'd8, rd, got);
    chk("cont_rd8_got", {31'h0, got}, 32'h1);
    chk("cont_rd8", rd, 32'hA0000000);
    read_word(6'd12, rd, got);
    chk("cont_rd12", rd, 32'hA0000010);
    read_word(6'd16, rd, got);
    chk("cont_rd16", rd, 32'hA0000020);
    read_word(6'd9, rd, got);
    chk("cont_rd9", rd, 32'h0);
    read_word(6'd14, rd, got);
    chk("cont_rd14", rd, 32'h0);

    // Reset during WAIT aborts a pending write
    req = 1'b1; we = 1'b1; addr = 6'd10; wdata = 32'h12345678;
    tick();
    req = 1'b0; we = 1'b0;
    chk("abort_busy_pre", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_ack",  {31'h0, ack},  32'h0);
    rst = 1'b0;
    tick();
    chk("abort_ack_a1", {31'h0, ack}, 32'h0);
    tick();
    chk("abort_ack_a2", {31'h0, ack}, 32'h0);
    read_word(6'd10, rd, got);
    chk("abort_rd10_got", {31'h0, got}, 32'h1);
    chk("abort_rd10", rd, 32'h0);
    read_word(6'h3F, rd, got);
    chk("abort_rd3f_cleared", rd, 32'h0);

    // Zero-wait instance: write at N, next acceptance (read) at N+2
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h3F; wdata0 = 32'hCAFEF00D;
    tick();
    chk("z_wr_ack",  {31'h0, ack0},  32'h1);
    chk("z_wr_busy", {31'h0, busy0}, 32'h1);
    we0 = 1'b0; wdata0 = 32'h0;
    tick();
    chk("z_n1_ack",  {31'h0, ack0},  32'h0);
    chk("z_n1_busy", {31'h0, busy0}, 32'h0);
    tick();
    chk("z_rd_ack",   {31'h0, ack0}, 32'h1);
    chk("z_rd_rdata", rdata0,        32'hCAFEF00D);
    req0 = 1'b0;
    tick();
    chk("z_done_ack", {31'h0, ack0}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- WAIT_CYCLES, 2, wait states inserted before each response; legal range 0..15.
- ADDR_W, 6, word-address width; storage depth is 2**ADDR_W words of 32 bits.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous, active-high.
- req, in, 1, request valid; sampled only in IDLE.
- we, in, 1, 1 = write, 0 = read; qualified by req.
- addr, in, ADDR_W, word address; qualified by req.
- wdata, in, 32, write data; qualified by req and we.
- ack, out, 1, one-cycle completion pulse.
- rdata, out, 32, read data; valid while ack=1 for a read.
- busy, out, 1, 1 while a request is in progress.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-004 Request acceptance:
- In IDLE with req=1 at an edge, the block SHALL capture we, addr and wdata into internal registers.
- On that edge it SHALL go to RESP if WAIT_CYCLES=0, otherwise to WAIT with the wait counter loaded with WAIT_CYCLES.
REQ-005 In WAIT, each edge SHALL decrement the 4-bit wait counter, or go to RESP when the counter equals 1.
REQ-006 Memory access SHALL occur on the edge that enters RESP, using only the captured request:
- Read: rdata <= mem[addr_q].
- Write: mem[addr_q] <= wdata_q, and rdata is unchanged.
REQ-007 ack SHALL be 1 exactly while in RESP (one cycle) and 0 otherwise.
REQ-008 RESP SHALL go to IDLE unconditionally on the next edge.
REQ-009 Latency: for a request sampled at edge N, ack SHALL be high between edges N+WAIT_CYCLES and N+WAIT_CYCLES+1.
REQ-010 Throughput: the earliest next acceptance SHALL be at edge N+WAIT_CYCLES+2.
REQ-011 busy SHALL equal (state != IDLE).
REQ-012 While busy=1, the block SHALL ignore req, we, addr and wdata; changes to them SHALL NOT affect the in-flight transaction.
REQ-013 A read of a word written by an earlier completed write SHALL return the written value; there is no read-during-write hazard, since transactions are serialized.
REQ-014 Addresses SHALL cover the full 0..2**ADDR_W-1 range with no wrap or error; address 2**ADDR_W-1 SHALL be a valid word.
REQ-015 The wait counter SHALL never underflow; WAIT_CYCLES=0 SHALL never enter WAIT.

Reset
REQ-016 While rst=1 at an edge, the block SHALL set:
- state = IDLE, wait counter = 0;
- ack = 0, busy = 0, rdata = 32'h0;
- every memory word = 32'h0.
REQ-017 rst SHALL take priority over every other input, including req=1 in the same cycle.
REQ-018 Reset asserted in WAIT or RESP SHALL abort the transaction:
- no ack SHALL be issued for it afterwards;
- a captured but uncommitted write SHALL be discarded.
REQ-019 On the first edge with rst=0, a req=1 SHALL be accepted normally.

Verification (WAIT_CYCLES=2 unless stated)
REQ-020 Read after reset: rst 1 -> 0, then read addr 5 accepted at edge N -> ack=1 only in the cycle after edge N+2, rdata=32'h0, busy=1 from N to N+3.
REQ-021 Write then read: write 32'hDEADBEEF to addr 6'h3F, wait for ack, then read 6'h3F -> second ack with rdata=32'hDEADBEEF; rdata unchanged during the write ack.
REQ-022 Continuous req with varying addr and data:
- requests are accepted at edges N, N+4, N+8, ...;
- each ack reflects only the values sampled at its acceptance edge;
- values changed during WAIT have no effect.
REQ-023 Reset mid-write: write 32'h12345678 to addr 10, assert rst during WAIT -> no ack, busy=0 after the reset edge; a later read of addr 10 returns 32'h0.
REQ-024 Instance with WAIT_CYCLES=0: a read accepted at edge N gives ack in the cycle after edge N, and the next acceptance occurs at edge N+2.
